// File: rtl/axi_master_pkg.sv
// Shared FSM state type and AXI encodings for the sample-moving AXI master.
package axi_master_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StAw   = 3'd1,
    StW    = 3'd2,
    StB    = 3'd3,
    StAr   = 3'd4,
    StR    = 3'd5,
    StDone = 3'd6
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_2B    = 3'b001;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] STRB_ALL   = 2'b11;

endpackage

// File: rtl/axi_sample_master_if.sv
// AXI write/read channel bundle between the sample master and its slave.
interface axi_sample_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2
);

  logic [11:0]           o_AWADDR;
  logic [7:0]            o_AWLEN;
  logic [2:0]            o_AWSIZE;
  logic [1:0]            o_AWBURST;
  logic [ID_WIDTH-1:0]   o_AWID;
  logic                  o_AWVALID;
  logic                  i_AWREADY;

  logic [15:0]           o_WDATA;
  logic [1:0]            o_WSTRB;
  logic                  o_WVALID;
  logic                  o_WLAST;
  logic                  i_WREADY;

  logic                  i_BVALID;
  logic [ID_WIDTH-1:0]   i_BID;
  logic                  o_BREADY;

  logic [11:0]           o_ARADDR;
  logic [7:0]            o_ARLEN;
  logic [2:0]            o_ARSIZE;
  logic [1:0]            o_ARBURST;
  logic [ID_WIDTH-1:0]   o_ARID;
  logic                  o_ARVALID;
  logic                  i_ARREADY;

  logic [DATA_WIDTH-1:0] i_RDATA;
  logic [ID_WIDTH-1:0]   i_RID;
  logic                  i_RVALID;
  logic                  i_RLAST;
  logic                  o_RREADY;

  modport master (
    output o_AWADDR, o_AWLEN, o_AWSIZE, o_AWBURST, o_AWID, o_AWVALID,
    input  i_AWREADY,
    output o_WDATA, o_WSTRB, o_WVALID, o_WLAST,
    input  i_WREADY,
    input  i_BVALID, i_BID,
    output o_BREADY,
    output o_ARADDR, o_ARLEN, o_ARSIZE, o_ARBURST, o_ARID, o_ARVALID,
    input  i_ARREADY,
    input  i_RDATA, i_RID, i_RVALID, i_RLAST,
    output o_RREADY
  );

  modport slave (
    input  o_AWADDR, o_AWLEN, o_AWSIZE, o_AWBURST, o_AWID, o_AWVALID,
    output i_AWREADY,
    input  o_WDATA, o_WSTRB, o_WVALID, o_WLAST,
    output i_WREADY,
    output i_BVALID, i_BID,
    input  o_BREADY,
    input  o_ARADDR, o_ARLEN, o_ARSIZE, o_ARBURST, o_ARID, o_ARVALID,
    output i_ARREADY,
    output i_RDATA, i_RID, i_RVALID, i_RLAST,
    input  o_RREADY
  );

endinterface

// File: rtl/axi_sample_master.sv
// Streams len+1 16-bit samples out as an AXI write burst, then reads len+1 words
// back and writes each one into the result sink.
module axi_sample_master
  import axi_master_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_start,
  input  logic [7:0]            i_len,
  input  logic [ID_WIDTH-1:0]   i_id,
  output logic [7:0]            o_src_addr,
  input  logic [15:0]           i_src_data,
  output logic                  o_res_we,
  output logic [7:0]            o_res_addr,
  output logic [DATA_WIDTH-1:0] o_res_data,
  axi_sample_master_if.master   m_axi,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [7:0]          r_len;
  logic [7:0]          w_len_nxt;
  logic [ID_WIDTH-1:0] r_id;
  logic [ID_WIDTH-1:0] w_id_nxt;
  logic [7:0]          r_beat;
  logic [7:0]          w_beat_nxt;
  logic                r_error;
  logic                w_error_nxt;
  logic                w_last_beat;

  assign w_last_beat = (r_beat == r_len);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= StIdle;
      r_len   <= '0;
      r_id    <= '0;
      r_beat  <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_id    <= w_id_nxt;
      r_beat  <= w_beat_nxt;
      r_error <= w_error_nxt;
    end
  end

  // Every output is decoded from registered state, so VALIDs never depend on READYs.
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_id_nxt    = r_id;
    w_beat_nxt  = r_beat;
    w_error_nxt = r_error;

    m_axi.o_AWADDR  = '0;
    m_axi.o_AWLEN   = '0;
    m_axi.o_AWSIZE  = '0;
    m_axi.o_AWBURST = '0;
    m_axi.o_AWID    = '0;
    m_axi.o_AWVALID = 1'b0;
    m_axi.o_WDATA   = '0;
    m_axi.o_WSTRB   = '0;
    m_axi.o_WVALID  = 1'b0;
    m_axi.o_WLAST   = 1'b0;
    m_axi.o_BREADY  = 1'b0;
    m_axi.o_ARADDR  = '0;
    m_axi.o_ARLEN   = '0;
    m_axi.o_ARSIZE  = '0;
    m_axi.o_ARBURST = '0;
    m_axi.o_ARID    = '0;
    m_axi.o_ARVALID = 1'b0;
    m_axi.o_RREADY  = 1'b0;
    o_src_addr      = '0;
    o_res_we        = 1'b0;
    o_res_addr      = '0;
    o_res_data      = '0;
    o_done          = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_len_nxt   = i_len;
          w_id_nxt    = i_id;
          w_error_nxt = 1'b0;
          w_state_nxt = StAw;
        end
      end

      StAw: begin
        m_axi.o_AWVALID = 1'b1;
        m_axi.o_AWLEN   = r_len;
        m_axi.o_AWSIZE  = SIZE_2B;
        m_axi.o_AWBURST = BURST_INCR;
        m_axi.o_AWID    = r_id;
        if (m_axi.i_AWREADY) begin
          w_beat_nxt  = '0;
          w_state_nxt = StW;
        end
      end

      StW: begin
        // The source port is zero-latency, so WDATA follows the beat counter directly.
        o_src_addr     = r_beat;
        m_axi.o_WVALID = 1'b1;
        m_axi.o_WDATA  = i_src_data;
        m_axi.o_WSTRB  = STRB_ALL;
        m_axi.o_WLAST  = w_last_beat;
        if (m_axi.i_WREADY) begin
          if (w_last_beat) begin
            w_state_nxt = StB;
          end else begin
            w_beat_nxt = r_beat + 8'd1;
          end
        end
      end

      StB: begin
        m_axi.o_BREADY = 1'b1;
        if (m_axi.i_BVALID) begin
          if (m_axi.i_BID != r_id) begin
            w_error_nxt = 1'b1;
          end
          w_state_nxt = StAr;
        end
      end

      StAr: begin
        m_axi.o_ARVALID = 1'b1;
        m_axi.o_ARLEN   = r_len;
        m_axi.o_ARSIZE  = SIZE_4B;
        m_axi.o_ARBURST = BURST_INCR;
        m_axi.o_ARID    = r_id;
        if (m_axi.i_ARREADY) begin
          w_beat_nxt  = '0;
          w_state_nxt = StR;
        end
      end

      StR: begin
        m_axi.o_RREADY = 1'b1;
        if (m_axi.i_RVALID) begin
          o_res_we   = 1'b1;
          o_res_addr = r_beat;
          o_res_data = m_axi.i_RDATA;
          // Either RLAST or the local count ends the burst; disagreement is a protocol error.
          if (m_axi.i_RLAST != w_last_beat || m_axi.i_RID != r_id) begin
            w_error_nxt = 1'b1;
          end
          if (m_axi.i_RLAST || w_last_beat) begin
            w_state_nxt = StDone;
          end else begin
            w_beat_nxt = r_beat + 8'd1;
          end
        end
      end

      StDone: begin
        o_done      = 1'b1;
        w_state_nxt = StIdle;
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  assign o_busy  = (r_state != StIdle);
  assign o_error = r_error;

endmodule

// File: tb/tb_axi_sample_master.sv
// Randomised bench: a behavioural AXI slave plus sample/result memories around the master.
module tb_axi_sample_master;

  localparam int DW = 32;
  localparam int IW = 2;

  logic          clk   = 1'b0;
  logic          rstn  = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    len   = '0;
  logic [IW-1:0] id    = '0;
  logic [7:0]    src_addr;
  logic [15:0]   src_data;
  logic          res_we;
  logic [7:0]    res_addr;
  logic [DW-1:0] res_data;
  logic          busy;
  logic          done;
  logic          error;
  logic [15:0]   src_mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign src_data = src_mem[src_addr];

  axi_sample_master_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) axi ();

  axi_sample_master #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_start    (start),
    .i_len      (len),
    .i_id       (id),
    .o_src_addr (src_addr),
    .i_src_data (src_data),
    .o_res_we   (res_we),
    .o_res_addr (res_addr),
    .o_res_data (res_data),
    .m_axi      (axi),
    .o_busy     (busy),
    .o_done     (done),
    .o_error    (error)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic slave_idle();
    axi.i_AWREADY = 1'b0;
    axi.i_WREADY  = 1'b0;
    axi.i_BVALID  = 1'b0;
    axi.i_BID     = '0;
    axi.i_ARREADY = 1'b0;
    axi.i_RVALID  = 1'b0;
    axi.i_RDATA   = '0;
    axi.i_RID     = '0;
    axi.i_RLAST   = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_ctrl"}, {axi.o_AWVALID, axi.o_WVALID, axi.o_WLAST, axi.o_BREADY,
                              axi.o_ARVALID, axi.o_RREADY, res_we, done, error, busy}, '0);
    check_eq({tag, "_aw"}, {axi.o_AWADDR, axi.o_AWLEN, axi.o_AWSIZE, axi.o_AWBURST, axi.o_AWID}, '0);
    check_eq({tag, "_ar"}, {axi.o_ARADDR, axi.o_ARLEN, axi.o_ARSIZE, axi.o_ARBURST, axi.o_ARID}, '0);
    check_eq({tag, "_w"}, {axi.o_WDATA, axi.o_WSTRB, src_addr}, '0);
    check_eq({tag, "_res"}, {res_addr, res_data}, '0);
  endtask

  // One write/read pair. rlast_at is the read beat carrying RLAST; abort_w > 0 resets
  // the DUT right after that many write beats have been accepted.
  task automatic run_txn(input int t_len, input int t_id, input int unsigned rdy_pct,
                         input int t_bid, input int t_rid, input int rlast_at, input int abort_w);
    logic [DW-1:0] rdata [256];
    logic [15:0]   stall_data;
    int  aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0, exp_r;
    bit  exp_err, bv = 0, rv = 0, r_end = 0, stall_w = 0, finished = 0, aborted = 0;

    for (int i = 0; i < 256; i++) begin
      src_mem[i] = 16'($urandom);
      rdata[i]   = DW'($urandom);
    end
    exp_r   = (rlast_at < t_len) ? rlast_at + 1 : t_len + 1;
    exp_err = (t_bid != t_id) || (t_rid != t_id) || (rlast_at != t_len);

    @(negedge clk);
    start = 1'b1;
    len   = 8'(t_len);
    id    = IW'(t_id);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      // Stray starts while busy must be ignored.
      start = (cyc > 0) && ($urandom_range(7) == 0);
      len   = 8'($urandom);
      id    = IW'($urandom);
      axi.i_AWREADY = ($urandom_range(99) < rdy_pct);
      axi.i_WREADY  = ($urandom_range(99) < rdy_pct);
      axi.i_ARREADY = ($urandom_range(99) < rdy_pct);
      axi.i_BVALID  = (w_n == t_len + 1) && (b_n == 0) && (bv || ($urandom_range(99) < rdy_pct));
      axi.i_BID     = IW'(t_bid);
      axi.i_RVALID  = (ar_n == 1) && !r_end && (rv || ($urandom_range(99) < rdy_pct));
      axi.i_RDATA   = rdata[r_n];
      axi.i_RID     = IW'(t_rid);
      axi.i_RLAST   = (r_n == rlast_at);
      #1;
      if (cyc == 0) begin
        check_eq("aw_first_cycle", axi.o_AWVALID, 1);
        check_eq("busy_on_start", busy, 1);
        check_eq("err_clear_on_start", error, 0);
      end
      if (stall_w) begin
        check_eq("w_valid_hold", axi.o_WVALID, 1);
        check_eq("w_data_hold", axi.o_WDATA, stall_data);
      end
      stall_w    = axi.o_WVALID && !axi.i_WREADY;
      stall_data = axi.o_WDATA;
      bv = axi.i_BVALID && !axi.o_BREADY;
      rv = axi.i_RVALID && !axi.o_RREADY;

      if (axi.o_AWVALID && axi.i_AWREADY) begin
        check_eq("aw_fields", {axi.o_AWADDR, axi.o_AWLEN, axi.o_AWSIZE, axi.o_AWBURST, axi.o_AWID},
                 {12'h000, 8'(t_len), 3'b001, 2'b01, IW'(t_id)});
        aw_n++;
      end
      if (axi.o_WVALID && axi.i_WREADY) begin
        check_eq("w_data", axi.o_WDATA, src_mem[w_n]);
        check_eq("w_last", axi.o_WLAST, (w_n == t_len));
        check_eq("w_strb", axi.o_WSTRB, 2'b11);
        w_n++;
        if (abort_w > 0 && w_n == abort_w) begin
          aborted = 1;
          break;
        end
      end
      if (axi.i_BVALID && axi.o_BREADY) b_n++;
      if (axi.o_ARVALID && axi.i_ARREADY) begin
        check_eq("ar_fields", {axi.o_ARADDR, axi.o_ARLEN, axi.o_ARSIZE, axi.o_ARBURST, axi.o_ARID},
                 {12'h000, 8'(t_len), 3'b010, 2'b01, IW'(t_id)});
        ar_n++;
      end
      check_eq("res_we", res_we, axi.i_RVALID && axi.o_RREADY);
      if (axi.i_RVALID && axi.o_RREADY) begin
        check_eq("res_addr", res_addr, r_n);
        check_eq("res_data", res_data, rdata[r_n]);
        r_end = axi.i_RLAST;
        r_n++;
      end
      if (done) begin
        start = 1'b0;
        finished = 1;
        check_eq("done_error", error, exp_err);
        check_eq("done_counts", {8'(aw_n), 8'(b_n), 8'(ar_n)}, {8'd1, 8'd1, 8'd1});
        check_eq("done_w_beats", w_n, t_len + 1);
        check_eq("done_r_beats", r_n, exp_r);
        break;
      end
    end

    start = 1'b0;
    if (aborted) begin
      @(posedge clk);
      #2;
      rstn = 1'b0;
      slave_idle();
      #1;
      check_quiet("async_rst");
      #1;
      rstn = 1'b1;
      return;
    end
    if (!finished) begin
      check_eq("timeout", 0, 1);
    end
    slave_idle();
    @(negedge clk);
    #1;
    check_eq("done_one_cycle", done, 0);
    check_eq("idle_after_done", busy, 0);
    check_eq("error_held", error, exp_err);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int r_len;
    int r_id;
    int r_rid;
    slave_idle();
    for (int i = 0; i < 256; i++) src_mem[i] = '0;
    #1 rstn = 1'b0;
    #2 check_quiet("reset");
    // Released during the high phase so the next rising edge is the first after reset.
    #14 rstn = 1'b1;

    run_txn(3, 2, 100, 2, 2, 3, 0);
    run_txn(7, 1, 50, 1, 1, 7, 0);
    run_txn(0, 3, 70, 3, 3, 0, 0);
    run_txn(2, 2, 100, 1, 2, 2, 0);
    run_txn(3, 0, 80, 0, 0, 3, 0);
    run_txn(3, 1, 100, 1, 1, 2, 0);
    run_txn(5, 2, 60, 2, 2, 5, 3);
    run_txn(4, 1, 100, 1, 1, 4, 0);
    run_txn(255, 3, 100, 3, 3, 255, 0);
    for (int k = 0; k < 6; k++) begin
      r_len = int'($urandom_range(15));
      r_id  = int'($urandom_range(3));
      r_rid = ($urandom_range(3) == 0) ? (r_id ^ 1) : r_id;
      run_txn(r_len, r_id, $urandom_range(100, 30), r_id, r_rid, r_len, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
